// File: rtl/biriscv_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between the two issue pipes.
// Optional watchdog on the divider writeback: define BIRISCV_DIV_ARB_TIMEOUT_EN.
module biriscv_div_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    output logic        req0_accept_o,
    input  logic [31:0] req0_opcode_i,
    input  logic [31:0] req0_pc_i,
    input  logic [4:0]  req0_rd_idx_i,
    input  logic [31:0] req0_ra_operand_i,
    input  logic [31:0] req0_rb_operand_i,

    input  logic        req1_valid_i,
    output logic        req1_accept_o,
    input  logic [31:0] req1_opcode_i,
    input  logic [31:0] req1_pc_i,
    input  logic [4:0]  req1_rd_idx_i,
    input  logic [31:0] req1_ra_operand_i,
    input  logic [31:0] req1_rb_operand_i,

    input  logic        flush_i,

    output logic        div_valid_o,
    output logic [31:0] div_opcode_o,
    output logic [31:0] div_pc_o,
    output logic [31:0] div_ra_operand_o,
    output logic [31:0] div_rb_operand_o,
    output logic [4:0]  div_rd_idx_o,

    input  logic        div_wb_valid_i,
    input  logic [31:0] div_wb_value_i,

    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic        resp_port_o,
    output logic [4:0]  resp_rd_idx_o,
    output logic [31:0] resp_value_o,

    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   rr_q;
    logic   grant_any;
    logic   grant1;
    logic   timeout_hit;

    // A sole requester always wins; on contention rr_q names the winner.
    assign grant1    = req1_valid_i & (~req0_valid_i | rr_q);
    assign grant_any = (state_q == ST_IDLE) & ~flush_i & (req0_valid_i | req1_valid_i);

    assign req0_accept_o = grant_any & ~grant1;
    assign req1_accept_o = grant_any & grant1;

    assign div_valid_o  = (state_q == ST_ISSUE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign busy_o       = (state_q != ST_IDLE);

`ifdef BIRISCV_DIV_ARB_TIMEOUT_EN
    logic [5:0] to_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            to_cnt_q <= 6'd0;
        else if (state_d != state_q)
            to_cnt_q <= 6'd0;
        else if (state_q == ST_WAIT || state_q == ST_DRAIN)
            to_cnt_q <= to_cnt_q + 6'd1;
    end

    assign timeout_hit = (state_q == ST_WAIT || state_q == ST_DRAIN) &&
                         (to_cnt_q == 6'd63) && !div_wb_valid_i;
    assign timeout_o   = timeout_hit;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = flush_i ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                // A flush coinciding with the writeback drops the result; the divider is already free.
                if (div_wb_valid_i)
                    state_d = flush_i ? ST_IDLE : ST_RESP;
                else if (timeout_hit)
                    state_d = ST_IDLE;
                else if (flush_i)
                    state_d = ST_DRAIN;
            end
            ST_RESP:  if (flush_i || resp_ready_i) state_d = ST_IDLE;
            ST_DRAIN: if (div_wb_valid_i || timeout_hit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_q             <= 1'b0;
            div_opcode_o     <= 32'd0;
            div_pc_o         <= 32'd0;
            div_ra_operand_o <= 32'd0;
            div_rb_operand_o <= 32'd0;
            div_rd_idx_o     <= 5'd0;
            resp_port_o      <= 1'b0;
            resp_rd_idx_o    <= 5'd0;
            resp_value_o     <= 32'd0;
        end else begin
            if (req0_accept_o) begin
                rr_q             <= 1'b1;
                div_opcode_o     <= req0_opcode_i;
                div_pc_o         <= req0_pc_i;
                div_ra_operand_o <= req0_ra_operand_i;
                div_rb_operand_o <= req0_rb_operand_i;
                div_rd_idx_o     <= req0_rd_idx_i;
                resp_port_o      <= 1'b0;
                resp_rd_idx_o    <= req0_rd_idx_i;
            end else if (req1_accept_o) begin
                rr_q             <= 1'b0;
                div_opcode_o     <= req1_opcode_i;
                div_pc_o         <= req1_pc_i;
                div_ra_operand_o <= req1_ra_operand_i;
                div_rb_operand_o <= req1_rb_operand_i;
                div_rd_idx_o     <= req1_rd_idx_i;
                resp_port_o      <= 1'b1;
                resp_rd_idx_o    <= req1_rd_idx_i;
            end

            if (state_q == ST_WAIT && div_wb_valid_i && !flush_i)
                resp_value_o <= div_wb_value_i;
        end
    end

endmodule

// File: tb/tb_biriscv_div_arbiter.sv
// Scoreboard bench for biriscv_div_arbiter with a behavioural divider stub.
// Define BIRISCV_DIV_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_biriscv_div_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_accept_o, req1_accept_o;
    logic [31:0] req0_opcode_i, req0_pc_i, req0_ra_operand_i, req0_rb_operand_i;
    logic [31:0] req1_opcode_i, req1_pc_i, req1_ra_operand_i, req1_rb_operand_i;
    logic [4:0]  req0_rd_idx_i, req1_rd_idx_i;
    logic        flush_i;
    logic        div_valid_o;
    logic [31:0] div_opcode_o, div_pc_o, div_ra_operand_o, div_rb_operand_o;
    logic [4:0]  div_rd_idx_o;
    logic        div_wb_valid_i;
    logic [31:0] div_wb_value_i;
    logic        resp_valid_o, resp_ready_i, resp_port_o;
    logic [4:0]  resp_rd_idx_o;
    logic [31:0] resp_value_o;
    logic        busy_o, timeout_o;

    biriscv_div_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_accept_o(req0_accept_o),
        .req0_opcode_i(req0_opcode_i), .req0_pc_i(req0_pc_i), .req0_rd_idx_i(req0_rd_idx_i),
        .req0_ra_operand_i(req0_ra_operand_i), .req0_rb_operand_i(req0_rb_operand_i),
        .req1_valid_i(req1_valid_i), .req1_accept_o(req1_accept_o),
        .req1_opcode_i(req1_opcode_i), .req1_pc_i(req1_pc_i), .req1_rd_idx_i(req1_rd_idx_i),
        .req1_ra_operand_i(req1_ra_operand_i), .req1_rb_operand_i(req1_rb_operand_i),
        .flush_i(flush_i),
        .div_valid_o(div_valid_o), .div_opcode_o(div_opcode_o), .div_pc_o(div_pc_o),
        .div_ra_operand_o(div_ra_operand_o), .div_rb_operand_o(div_rb_operand_o),
        .div_rd_idx_o(div_rd_idx_o),
        .div_wb_valid_i(div_wb_valid_i), .div_wb_value_i(div_wb_value_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_port_o(resp_port_o),
        .resp_rd_idx_o(resp_rd_idx_o), .resp_value_o(resp_value_o),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        port;
        logic [4:0]  rd;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic [4:0] rd, input logic [31:0] value);
        exp_t e;
        e.port  = port;
        e.rd    = rd;
        e.value = value;
        sb_q.push_back(e);
    endtask

    // R-type M-extension encoding; funct3 selects DIV(4)/DIVU(5)/REM(6)/REMU(7).
    function automatic logic [31:0] mk_op(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd0, 5'd0, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op[14:12])
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Divider stub: writeback stub_lat cycles after the start pulse.
    int          stub_lat  = 4;
    bit          stub_en   = 1'b1;
    bit          stub_pend = 1'b0;
    int          stub_cnt  = 0;
    logic [31:0] stub_op, stub_a, stub_b;

    initial begin
        div_wb_valid_i = 1'b0;
        div_wb_value_i = 32'd0;
        forever begin
            @(posedge clk_i);
            #1;
            div_wb_valid_i = 1'b0;
            if (!rst_i) begin
                stub_pend = 1'b0;
            end else begin
                if (stub_pend) begin
                    stub_cnt--;
                    if (stub_cnt == 0) begin
                        div_wb_valid_i = 1'b1;
                        div_wb_value_i = ref_div(stub_op, stub_a, stub_b);
                        stub_pend      = 1'b0;
                    end
                end
                if (div_valid_o) begin
                    check("no_restart_while_busy", 32'(stub_pend), 32'd0);
                    if (stub_en) begin
                        stub_pend = 1'b1;
                        stub_cnt  = stub_lat;
                        stub_op   = div_opcode_o;
                        stub_a    = div_ra_operand_o;
                        stub_b    = div_rb_operand_o;
                    end
                end
            end
        end
    end

    // Monitor: every completed response handshake is compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (resp_valid_o && resp_ready_i) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: port=%0d rd=%0d value=0x%08h, expected no response",
                             resp_port_o, resp_rd_idx_o, resp_value_o);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_port",  32'(resp_port_o),   32'(e.port));
                    check("resp_rd",    32'(resp_rd_idx_o), 32'(e.rd));
                    check("resp_value", resp_value_o,       e.value);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input bit p, input logic [31:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        if (p) begin
            req1_opcode_i = op; req1_pc_i = 32'h1000_0100; req1_rd_idx_i = rd;
            req1_ra_operand_i = a; req1_rb_operand_i = b; req1_valid_i = 1'b1;
        end else begin
            req0_opcode_i = op; req0_pc_i = 32'h1000_0000; req0_rd_idx_i = rd;
            req0_ra_operand_i = a; req0_rb_operand_i = b; req0_valid_i = 1'b1;
        end
    endtask

    // Returns at posedge+1 of the cycle after the accept, with the request dropped.
    task automatic wait_accept(input bit p, input string name);
        int n = 0;
        @(negedge clk_i);
        while (!(p ? req1_accept_o : req0_accept_o) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check(name, 32'(p ? req1_accept_o : req0_accept_o), 32'd1);
        step();
        if (p) req1_valid_i = 1'b0;
        else   req0_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk_i);
        while ((busy_o || sb_q.size() != 0) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_idle"}, 32'(busy_o), 32'd0);
        check({name, "_sb_empty"}, sb_q.size(), 32'd0);
        step();
    endtask

    initial begin
        req0_valid_i = 1'b0; req1_valid_i = 1'b0; flush_i = 1'b0; resp_ready_i = 1'b1;
        req0_opcode_i = '0; req0_pc_i = '0; req0_rd_idx_i = '0; req0_ra_operand_i = '0; req0_rb_operand_i = '0;
        req1_opcode_i = '0; req1_pc_i = '0; req1_rd_idx_i = '0; req1_ra_operand_i = '0; req1_rb_operand_i = '0;

        // Reset state
        rst_i = 1'b0;
        repeat (3) step();
        check("rst_busy",       32'(busy_o),       32'd0);
        check("rst_div_valid",  32'(div_valid_o),  32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_div_opcode", div_opcode_o,      32'd0);
        check("rst_div_ra",     div_ra_operand_o,  32'd0);
        check("rst_resp_value", resp_value_o,      32'd0);
        check("rst_timeout",    32'(timeout_o),    32'd0);
        rst_i = 1'b1;
        step();

        // Pipe 0 only: DIV 100/7 -> 14, accept at T, start pulse only at T+1
        push_exp(1'b0, 5'd5, 32'd14);
        set_req(1'b0, mk_op(3'd4, 5'd5), 32'd100, 32'd7, 5'd5);
        @(negedge clk_i);
        check("t1_acc0",           32'(req0_accept_o), 32'd1);
        check("t1_acc1",           32'(req1_accept_o), 32'd0);
        check("t1_div_valid_at_T", 32'(div_valid_o),   32'd0);
        step();
        req0_valid_i = 1'b0;
        check("t1_div_valid_T1", 32'(div_valid_o),   32'd1);
        check("t1_div_opcode",   div_opcode_o,       mk_op(3'd4, 5'd5));
        check("t1_div_ra",       div_ra_operand_o,   32'd100);
        check("t1_div_rb",       div_rb_operand_o,   32'd7);
        check("t1_div_rd",       32'(div_rd_idx_o),  32'd5);
        check("t1_busy",         32'(busy_o),        32'd1);
        step();
        check("t1_div_valid_T2", 32'(div_valid_o),   32'd0);
        wait_idle("t1");

        // Reset in the middle of an operation clears everything at once
        set_req(1'b1, mk_op(3'd5, 5'd1), 32'd5, 32'd1, 5'd1);
        wait_accept(1'b1, "mr_acc1");
        step();
        step();
        rst_i = 1'b0;
        #1;
        check("mr_busy",       32'(busy_o),      32'd0);
        check("mr_div_valid",  32'(div_valid_o), 32'd0);
        check("mr_div_rd",     32'(div_rd_idx_o), 32'd0);
        repeat (2) step();
        rst_i = 1'b1;
        step();

        // Simultaneous pair from reset: pipe 0 first, then pipe 1
        push_exp(1'b0, 5'd3, 32'd2);
        push_exp(1'b1, 5'd7, 32'h7FFF_FFFF);
        set_req(1'b0, mk_op(3'd6, 5'd3), 32'd100, 32'd7, 5'd3);
        set_req(1'b1, mk_op(3'd5, 5'd7), 32'hFFFF_FFFF, 32'd2, 5'd7);
        @(negedge clk_i);
        check("pa_acc0", 32'(req0_accept_o), 32'd1);
        check("pa_acc1", 32'(req1_accept_o), 32'd0);
        step();
        req0_valid_i = 1'b0;
        wait_accept(1'b1, "pa_acc1_later");
        wait_idle("pa");

        // Divide by zero with a stalled consumer: response held, no new accept
        resp_ready_i = 1'b0;
        push_exp(1'b0, 5'd9, 32'hFFFF_FFFF);
        set_req(1'b0, mk_op(3'd4, 5'd9), 32'd9, 32'd0, 5'd9);
        wait_accept(1'b0, "dz_acc");
        begin
            int n = 0;
            @(negedge clk_i);
            while (!resp_valid_o && n < 300) begin
                @(negedge clk_i);
                n++;
            end
            check("dz_resp_valid", 32'(resp_valid_o), 32'd1);
        end
        step();
        push_exp(1'b0, 5'd2, 32'd10);
        set_req(1'b0, mk_op(3'd5, 5'd2), 32'd50, 32'd5, 5'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("dz_hold_valid", 32'(resp_valid_o),  32'd1);
            check("dz_hold_value", resp_value_o,       32'hFFFF_FFFF);
            check("dz_hold_rd",    32'(resp_rd_idx_o), 32'd9);
            check("dz_hold_noacc", 32'(req0_accept_o), 32'd0);
        end
        step();
        resp_ready_i = 1'b1;
        wait_accept(1'b0, "dz_next_acc");
        wait_idle("dz");

        // Second simultaneous pair after a pipe 0 grant: pipe 1 first
        push_exp(1'b1, 5'd6, 32'hFFFF_FFFA);
        push_exp(1'b0, 5'd4, 32'd2);
        set_req(1'b0, mk_op(3'd7, 5'd4), 32'd17, 32'd5, 5'd4);
        set_req(1'b1, mk_op(3'd4, 5'd6), 32'hFFFF_FFEC, 32'd3, 5'd6);
        @(negedge clk_i);
        check("pb_acc1", 32'(req1_accept_o), 32'd1);
        check("pb_acc0", 32'(req0_accept_o), 32'd0);
        step();
        req1_valid_i = 1'b0;
        wait_accept(1'b0, "pb_acc0_later");
        wait_idle("pb");

        // Flush 5 cycles after the start pulse; pipe 1 waits for the drain
        stub_lat = 8;
        set_req(1'b0, mk_op(3'd4, 5'd1), 32'd40, 32'd4, 5'd1);
        wait_accept(1'b0, "fl_acc0");
        push_exp(1'b1, 5'd8, 32'd9);
        set_req(1'b1, mk_op(3'd5, 5'd8), 32'd81, 32'd9, 5'd8);
        repeat (5) step();
        flush_i = 1'b1;
        @(negedge clk_i);
        check("fl_noacc_during_flush", 32'(req1_accept_o), 32'd0);
        step();
        flush_i = 1'b0;
        begin
            int n = 0;
            @(negedge clk_i);
            while (!req1_accept_o && n < 300) begin
                @(negedge clk_i);
                n++;
            end
            check("fl_acc1", 32'(req1_accept_o), 32'd1);
            check("fl_drained_before_acc", 32'(stub_pend), 32'd0);
        end
        step();
        req1_valid_i = 1'b0;
        check("fl_div_valid", 32'(div_valid_o),  32'd1);
        check("fl_div_rd",    32'(div_rd_idx_o), 32'd8);
        wait_idle("fl");
        stub_lat = 4;

        // Flush in the same cycle as the writeback: dropped, IDLE next cycle
        set_req(1'b0, mk_op(3'd4, 5'd1), 32'd40, 32'd4, 5'd1);
        wait_accept(1'b0, "fw_acc");
        repeat (4) step();
        flush_i = 1'b1;
        @(negedge clk_i);
        check("fw_busy_at_wb", 32'(busy_o), 32'd1);
        step();
        flush_i = 1'b0;
        check("fw_idle",       32'(busy_o),       32'd0);
        check("fw_no_resp",    32'(resp_valid_o), 32'd0);
        repeat (3) step();

`ifdef BIRISCV_DIV_ARB_TIMEOUT_EN
        // Writeback never arrives: watchdog fires 63 cycles after WAIT entry
        stub_en = 1'b0;
        set_req(1'b1, mk_op(3'd4, 5'd1), 32'd1, 32'd1, 5'd1);
        wait_accept(1'b1, "to_acc");
        step();
        begin
            int n = 0;
            @(negedge clk_i);
            while (!timeout_o && n < 100) begin
                @(negedge clk_i);
                n++;
            end
            check("to_cycles", n, 32'd63);
        end
        step();
        check("to_pulse_len", 32'(timeout_o),    32'd0);
        check("to_idle",      32'(busy_o),       32'd0);
        check("to_no_resp",   32'(resp_valid_o), 32'd0);
        stub_en = 1'b1;
        push_exp(1'b0, 5'd2, 32'd3);
        set_req(1'b0, mk_op(3'd5, 5'd2), 32'd7, 32'd2, 5'd2);
        wait_accept(1'b0, "to_next_acc");
        wait_idle("to");
`else
        check("to_tied_off", 32'(timeout_o), 32'd0);
`endif

        check("end_busy", 32'(busy_o), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/biriscv_div_arbiter.md
# biriscv_div_arbiter

Shares the single iterative `biriscv_divider` between the two issue pipes of the dual-issue core. It accepts DIV/DIVU/REM/REMU requests from pipe 0 and pipe 1 and picks one with round-robin priority. It issues that request to the divider as a single-cycle start pulse, then holds off further issue until the divider writes back. The result is returned, tagged with the originating pipe and destination register, over a valid/ready response port; flushes discard in-flight work safely.

## Interface
- No parameters.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: asynchronous active-low reset.
- `req0_valid_i`, `req1_valid_i` in 1: divide request pending from pipe 0 / pipe 1.
- `req0_accept_o`, `req1_accept_o` out 1: request taken this cycle; the requester drops or advances it next cycle.
- `reqN_opcode_i` in 32, `reqN_pc_i` in 32, `reqN_rd_idx_i` in 5, `reqN_ra_operand_i` in 32, `reqN_rb_operand_i` in 32: request payload, N = 0/1.
- `flush_i` in 1: pipeline flush; kill queued or in-flight work.
- `div_valid_o` out 1: start pulse to the divider (`opcode_valid_i`).
- `div_opcode_o`, `div_pc_o`, `div_ra_operand_o`, `div_rb_operand_o` out 32; `div_rd_idx_o` out 5: registered payload to the divider. The divider's `invalid`/`ra_idx`/`rb_idx` inputs are tied 0 at the parent.
- `div_wb_valid_i` in 1, `div_wb_value_i` in 32: divider writeback.
- `resp_valid_o` out 1, `resp_ready_i` in 1: result handshake.
- `resp_port_o` out 1, `resp_rd_idx_o` out 5, `resp_value_o` out 32: originating pipe, destination register, result.
- `busy_o` out 1: state is not IDLE.
- `timeout_o` out 1: watchdog fired (see Configuration).

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- **IDLE**
  - If any `reqN_valid_i` and `!flush_i`, grant one requester. The accept is combinational, same cycle as the grant.
  - The payload is registered into the `div_*` outputs and the granted pipe is recorded. Next state is ISSUE.
- **Round-robin pointer**
  - `rr_q` resets to 0, which gives pipe 0 priority.
  - If both pipes request, the pipe named by `rr_q` wins. A sole requester always wins.
  - On each grant to pipe p, `rr_q <= ~p`.
- **ISSUE**: `div_valid_o = 1` for exactly this one cycle, then WAIT. A flush in ISSUE still emits the pulse, then goes to DRAIN.
- **WAIT**
  - On `div_wb_valid_i`, capture `div_wb_value_i` into `resp_value_o`, then go to RESP.
  - A flush without a writeback in the same cycle goes to DRAIN.
  - A flush in the same cycle as the writeback drops the value and goes to IDLE.
- **RESP**
  - `resp_valid_o = 1`, with port, rd and value held stable until `resp_ready_i`, then IDLE.
  - A flush in RESP drops the result and goes to IDLE, with no handshake required.
- **DRAIN**
  - Wait for `div_wb_valid_i`, discard it, then go to IDLE. Requests are not accepted.
  - This guarantees the divider is never restarted while busy.
- `div_valid_o` is never asserted outside ISSUE. Only one operation is outstanding at any time.
- Both accepts are 0 in every state except IDLE.
- `busy_o = (state != IDLE)`.

## Timing
- Reset values: all outputs 0, state IDLE, `rr_q` 0.
- Accept (cycle T) gives `div_valid_o` at T+1.
- The writeback arrives at a divider-dependent latency:
  - about 34 cycles after the start pulse for a new operation;
  - 2 cycles for an operand/opcode repeat.
- `resp_valid_o` rises the cycle after `div_wb_valid_i`.
- Minimum accept-to-accept spacing is latency + 3 cycles, with `resp_ready_i` held high.
- Reset asserted mid-operation clears all state immediately. The divider shares the reset, so no drain is needed.

## Configuration
- `BIRISCV_DIV_ARB_TIMEOUT_EN` defined:
  - A 6-bit counter clears on entering WAIT/DRAIN and increments each cycle in those states.
  - When it reaches 63 without a writeback, `timeout_o` pulses for one cycle and the state forces to IDLE with no response.
- Undefined: no counter; `timeout_o` is tied 0; WAIT/DRAIN wait indefinitely.

## Test plan
- Pipe 0 only, DIV ra=100 rb=7, rd=5 → `req0_accept_o` at T, `div_valid_o` one cycle at T+1, response port=0 rd=5 value=14.
- Both pipes valid in the same cycle:
  - from reset, REM 100/7 on pipe 0 and DIVU 0xFFFFFFFF/2 on pipe 1 → pipe 0 granted first (value 2), then pipe 1 (0x7FFFFFFF);
  - a second simultaneous pair → pipe 1 granted first.
- DIV by zero (ra=9, rb=0) → value 0xFFFFFFFF; `resp_ready_i` held low 10 cycles → `resp_valid_o` and value stay stable, with no new accept.
- Flush 5 cycles after `div_valid_o`, with pipe 1 requesting:
  - no response, and pipe 1 is not accepted until the divider's writeback is drained;
  - then pipe 1 is accepted and its `div_valid_o` follows.
- Flush in the same cycle as `div_wb_valid_i` → no response; state returns to IDLE next cycle.
- With `BIRISCV_DIV_ARB_TIMEOUT_EN`, writeback stubbed never-valid → `timeout_o` pulses 63 cycles after WAIT entry, and the next request is accepted.
